game_mode_sequencer: RTL and testbench
======================================

# game_mode_sequencer

Frame-synchronous game-state controller for the VGA display path. It sequences title, play, respawn, level-up, game-over and win phases, and drives the `isGameMode` gate and the splash-screen selection that feed the pixel objects mux. Gameplay units report events (player hit, aliens cleared, aliens landed). The block latches these events and applies state changes only at frame boundaries, so layer priority never changes mid-frame.

## Interface
Parameters:
- LIVES, 3: lives at game start (1..3).
- MAX_LEVEL, 4: last level; clearing it leads to WIN (1..7).
- SPLASH_MIN_FRAMES, 60: frames a splash must show before startKey is honoured.
- RESPAWN_FRAMES, 90: freeze length after a hit.
- LEVELUP_FRAMES, 60: pause between levels.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  synchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- startKey  in  1  one-cycle pulse.
- pauseKey  in  1  one-cycle pulse.
- playerHit  in  1  one-cycle pulse.
- aliensCleared  in  1  one-cycle pulse.
- aliensLanded  in  1  one-cycle pulse.
- isGameMode  out  1  high in PLAY, RESPAWN and PAUSE.
- splashEn  out  1  enables the splash drawer.
- splashSel  out  2  splash image: 0 title, 1 level-up, 2 game over, 3 win.
- freeze  out  1  halts all motion units (RESPAWN, LEVEL_UP, PAUSE).
- gameResetPulse  out  1  one-cycle pulse telling gameplay units to reinitialise the field.
- livesLeft  out  2  lives remaining.
- level  out  3  current level, starting at 1.

## Operation
- Event capture: each input pulse sets its own sticky flag on the next edge. All flags clear on the edge that consumes startOfFrame. A pulse arriving in the same cycle as startOfFrame is held for the next frame.
- Frame counter `frameCnt` (8 bit):
  - Clears on every state change.
  - Increments on each startOfFrame.
  - Saturates at 255.
- States and transitions. All transitions are evaluated only on startOfFrame.
  - TITLE: splashEn=1, splashSel=0. If startKey is set and frameCnt ≥ SPLASH_MIN_FRAMES, go to PLAY. On entry to PLAY, livesLeft=LIVES, level=1, gameResetPulse is asserted.
  - PLAY: applies events in priority order aliensLanded > playerHit > aliensCleared > pauseKey.
    - aliensLanded: go to GAME_OVER.
    - playerHit: decrement livesLeft. If livesLeft was 1, go to GAME_OVER (livesLeft=0); otherwise go to RESPAWN.
    - aliensCleared: if level==MAX_LEVEL go to WIN, else go to LEVEL_UP.
    - pauseKey: go to PAUSE.
  - RESPAWN: freeze=1. Hits are ignored. When frameCnt==RESPAWN_FRAMES-1, return to PLAY.
  - LEVEL_UP: splashEn=1, splashSel=1, freeze=1. When frameCnt==LEVELUP_FRAMES-1, increment level, assert gameResetPulse, go to PLAY.
  - PAUSE: freeze=1, isGameMode=1. pauseKey returns to PLAY. Other events are discarded.
  - GAME_OVER: splashSel=2. WIN: splashSel=3. Both: splashEn=1, isGameMode=0. If startKey and frameCnt ≥ SPLASH_MIN_FRAMES, go to TITLE.
- Arithmetic:
  - livesLeft never underflows.
  - level never exceeds MAX_LEVEL.
  - frameCnt comparisons are unsigned, 8 bit.

## Timing
- Reset values (while resetN=0 at a clk edge): state TITLE, isGameMode=0, splashEn=1, splashSel=0, freeze=0, gameResetPulse=0, livesLeft=LIVES, level=1, frameCnt=0, all flags clear.
- Outputs are registered and update on the same edge as the state register.
- Latency: event pulse at cycle n, startOfFrame at cycle m > n, so new outputs are visible at m+1. Latency is therefore at most one frame plus one cycle.
- gameResetPulse is high for exactly cycle m+1.
- Reset asserted mid-frame or mid-sequence returns the block to TITLE on the next edge, with no pulse output.

## Configuration
- PAUSE_EN defined: PAUSE state and pauseKey handling are present.
- PAUSE_EN undefined: pauseKey is ignored, PAUSE is unreachable, and its encoding is removed from the package.

## Structure
- Package `game_mode_pkg` holds:
  - state enum `game_state_t`;
  - splashSel constants `SPLASH_TITLE`, `SPLASH_LEVELUP`, `SPLASH_GAMEOVER`, `SPLASH_WIN`.
- Sub-module `frame_event_latch`: holds the sticky flags and the clear-on-startOfFrame logic, parameterised by event count.
- The FSM and counters live in the top module.

## Test plan
- Reset, then startKey at frame 10 → ignored. startKey at frame 61 → PLAY after next startOfFrame, with gameResetPulse for one cycle, livesLeft=3, level=1, isGameMode=1.
- In PLAY, three playerHit pulses, each separated by RESPAWN_FRAMES+2 frames:
  - after the first hit: RESPAWN, livesLeft=2, freeze=1 for 90 frames;
  - after the third hit: GAME_OVER, livesLeft=0, splashSel=2.
- playerHit and aliensLanded in the same frame → GAME_OVER, livesLeft unchanged.
- aliensCleared at level 1 → LEVEL_UP, splashSel=1. After 60 frames: level=2, PLAY, gameResetPulse. aliensCleared at level 4 → WIN, splashSel=3.
- With PAUSE_EN: pauseKey → PAUSE, freeze=1. playerHit is discarded. pauseKey → PLAY, livesLeft unchanged. Without PAUSE_EN: pauseKey → no change.
- Event pulse coincident with startOfFrame → acted on at the following frame. resetN low during RESPAWN → TITLE on the next edge with reset values.

Source files
------------

// File: rtl/game_mode_sequencer_pkg.sv
// Shared types for the game-mode sequencer: FSM state enum, event indices, splash codes.
// Latency: n/a (types only).  Backpressure: n/a.
// Optional feature macro: PAUSE_EN adds the PAUSE state and the pauseKey event slot.
package game_mode_pkg;

`ifdef PAUSE_EN
  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5,
    S_PAUSE     = 3'd6
  } game_state_t;
  localparam int NUM_EVT = 5;
`else
  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5
  } game_state_t;
  localparam int NUM_EVT = 4;
`endif

  // Bit positions of the sticky event flags.
  localparam int EV_START   = 0;
  localparam int EV_HIT     = 1;
  localparam int EV_CLEARED = 2;
  localparam int EV_LANDED  = 3;
  localparam int EV_PAUSE   = 4;

  localparam logic [1:0] SPLASH_TITLE    = 2'd0;
  localparam logic [1:0] SPLASH_LEVELUP  = 2'd1;
  localparam logic [1:0] SPLASH_GAMEOVER = 2'd2;
  localparam logic [1:0] SPLASH_WIN      = 2'd3;

  // Level advance that never passes the last level.
  function automatic logic [2:0] level_inc(input logic [2:0] lvl, input logic [2:0] max_lvl);
    return (lvl < max_lvl) ? lvl + 3'd1 : lvl;
  endfunction

endpackage

// File: rtl/game_mode_sequencer_if.sv
// Bundle of frame/event inputs and display-control outputs of the game-mode sequencer.
// Latency: n/a (wiring only).  Backpressure: none, all signals are pulses or levels.
// Ports: master = event sources/observers, slave = the sequencer.
interface game_mode_sequencer_if;
  logic       startOfFrame;
  logic       startKey;
  logic       pauseKey;
  logic       playerHit;
  logic       aliensCleared;
  logic       aliensLanded;
  logic       isGameMode;
  logic       splashEn;
  logic [1:0] splashSel;
  logic       freeze;
  logic       gameResetPulse;
  logic [1:0] livesLeft;
  logic [2:0] level;

  modport master (
    output startOfFrame, startKey, pauseKey, playerHit, aliensCleared, aliensLanded,
    input  isGameMode, splashEn, splashSel, freeze, gameResetPulse, livesLeft, level
  );

  modport slave (
    input  startOfFrame, startKey, pauseKey, playerHit, aliensCleared, aliensLanded,
    output isGameMode, splashEn, splashSel, freeze, gameResetPulse, livesLeft, level
  );
endinterface

// File: rtl/game_mode_sequencer_frame_event_latch.sv
// Sticky per-event flags collected over one frame, consumed at startOfFrame.
// Latency: a pulse shows in flag one cycle later.  Backpressure: none, pulses never lost.
// Ports: clk, resetN (sync active-low), sof, pulse[N] in; flag[N] out.
module frame_event_latch #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         sof,
  input  logic [N-1:0] pulse,
  output logic [N-1:0] flag
);

  // On the consuming edge the old flags are dropped, but a pulse arriving in
  // that same cycle is kept so it is seen at the following frame boundary.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      flag <= '0;
    end else if (sof) begin
      flag <= pulse;
    end else begin
      flag <= flag | pulse;
    end
  end

endmodule

// File: rtl/game_mode_sequencer.sv
// Frame-synchronous game phase controller: title/play/respawn/level-up/game-over/win (+pause with PAUSE_EN).
// Latency: event at cycle n, next startOfFrame at m>n, outputs change at m+1.  Backpressure: none.
// Ports: clk, resetN (sync active-low), bus (slave modport: frame/event pulses in, display controls out).
module game_mode_sequencer
  import game_mode_pkg::*;
#(
  parameter int LIVES             = 3,
  parameter int MAX_LEVEL         = 4,
  parameter int SPLASH_MIN_FRAMES = 60,
  parameter int RESPAWN_FRAMES    = 90,
  parameter int LEVELUP_FRAMES    = 60
) (
  input logic                 clk,
  input logic                 resetN,
  game_mode_sequencer_if.slave bus
);

  localparam logic [1:0] LIVES_INIT   = 2'(LIVES);
  localparam logic [2:0] MAX_LVL      = 3'(MAX_LEVEL);
  localparam logic [7:0] SPLASH_MIN   = 8'(SPLASH_MIN_FRAMES);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] LEVELUP_LAST = 8'(LEVELUP_FRAMES - 1);

  logic [NUM_EVT-1:0] pulse;
  logic [NUM_EVT-1:0] flag;
  logic               sof;

  game_state_t state, state_nxt;
  logic [7:0]  frame_cnt;
  logic [1:0]  lives, lives_nxt;
  logic [2:0]  level, level_nxt;
  logic        reset_pulse_nxt;

  logic        is_game, splash_en, freeze, reset_pulse;
  logic [1:0]  splash_sel;

  assign sof                 = bus.startOfFrame;
  assign pulse[EV_START]     = bus.startKey;
  assign pulse[EV_HIT]       = bus.playerHit;
  assign pulse[EV_CLEARED]   = bus.aliensCleared;
  assign pulse[EV_LANDED]    = bus.aliensLanded;
`ifdef PAUSE_EN
  assign pulse[EV_PAUSE]     = bus.pauseKey;
`endif

  frame_event_latch #(.N(NUM_EVT)) u_latch (
    .clk    (clk),
    .resetN (resetN),
    .sof    (sof),
    .pulse  (pulse),
    .flag   (flag)
  );

  // Next-state logic; nothing moves except on a frame boundary.
  always_comb begin
    state_nxt       = state;
    lives_nxt       = lives;
    level_nxt       = level;
    reset_pulse_nxt = 1'b0;
    if (sof) begin
      unique case (state)
        S_TITLE: begin
          if (flag[EV_START] && frame_cnt >= SPLASH_MIN) begin
            state_nxt       = S_PLAY;
            lives_nxt       = LIVES_INIT;
            level_nxt       = 3'd1;
            reset_pulse_nxt = 1'b1;
          end
        end
        S_PLAY: begin
          // Landing outranks a hit, so a simultaneous hit keeps the lives count.
          if (flag[EV_LANDED]) begin
            state_nxt = S_GAME_OVER;
          end else if (flag[EV_HIT]) begin
            if (lives <= 2'd1) begin
              lives_nxt = 2'd0;
              state_nxt = S_GAME_OVER;
            end else begin
              lives_nxt = lives - 2'd1;
              state_nxt = S_RESPAWN;
            end
          end else if (flag[EV_CLEARED]) begin
            state_nxt = (level >= MAX_LVL) ? S_WIN : S_LEVEL_UP;
          end
`ifdef PAUSE_EN
          else if (flag[EV_PAUSE]) begin
            state_nxt = S_PAUSE;
          end
`endif
        end
        S_RESPAWN: begin
          if (frame_cnt == RESPAWN_LAST) state_nxt = S_PLAY;
        end
        S_LEVEL_UP: begin
          if (frame_cnt == LEVELUP_LAST) begin
            state_nxt       = S_PLAY;
            level_nxt       = level_inc(level, MAX_LVL);
            reset_pulse_nxt = 1'b1;
          end
        end
`ifdef PAUSE_EN
        S_PAUSE: begin
          if (flag[EV_PAUSE]) state_nxt = S_PLAY;
        end
`endif
        S_GAME_OVER, S_WIN: begin
          if (flag[EV_START] && frame_cnt >= SPLASH_MIN) state_nxt = S_TITLE;
        end
        default: state_nxt = S_TITLE;
      endcase
    end
  end

  // Output decode from the next state so outputs flop together with the state.
  logic       is_game_nxt, splash_en_nxt, freeze_nxt;
  logic [1:0] splash_sel_nxt;

  always_comb begin
    is_game_nxt    = 1'b0;
    splash_en_nxt  = 1'b0;
    splash_sel_nxt = SPLASH_TITLE;
    freeze_nxt     = 1'b0;
    unique case (state_nxt)
      S_TITLE:     splash_en_nxt = 1'b1;
      S_PLAY:      is_game_nxt   = 1'b1;
      S_RESPAWN: begin
        is_game_nxt = 1'b1;
        freeze_nxt  = 1'b1;
      end
      S_LEVEL_UP: begin
        splash_en_nxt  = 1'b1;
        splash_sel_nxt = SPLASH_LEVELUP;
        freeze_nxt     = 1'b1;
      end
`ifdef PAUSE_EN
      S_PAUSE: begin
        is_game_nxt = 1'b1;
        freeze_nxt  = 1'b1;
      end
`endif
      S_GAME_OVER: begin
        splash_en_nxt  = 1'b1;
        splash_sel_nxt = SPLASH_GAMEOVER;
      end
      S_WIN: begin
        splash_en_nxt  = 1'b1;
        splash_sel_nxt = SPLASH_WIN;
      end
      default:     splash_en_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= S_TITLE;
      frame_cnt   <= 8'd0;
      lives       <= LIVES_INIT;
      level       <= 3'd1;
      is_game     <= 1'b0;
      splash_en   <= 1'b1;
      splash_sel  <= SPLASH_TITLE;
      freeze      <= 1'b0;
      reset_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      lives       <= lives_nxt;
      level       <= level_nxt;
      is_game     <= is_game_nxt;
      splash_en   <= splash_en_nxt;
      splash_sel  <= splash_sel_nxt;
      freeze      <= freeze_nxt;
      reset_pulse <= reset_pulse_nxt;
      // Counts frames spent in the current state, saturating.
      if (state_nxt != state) begin
        frame_cnt <= 8'd0;
      end else if (sof && frame_cnt != 8'hFF) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign bus.isGameMode     = is_game;
  assign bus.splashEn       = splash_en;
  assign bus.splashSel      = splash_sel;
  assign bus.freeze         = freeze;
  assign bus.gameResetPulse = reset_pulse;
  assign bus.livesLeft      = lives;
  assign bus.level          = level;

endmodule

// File: tb/tb_game_mode_sequencer.sv
// Testbench for game_mode_sequencer: frame-paced directed + random events against a phase-level model.
// Expected outputs are queued at each frame boundary / reset and popped by an independent monitor.
module tb_game_mode_sequencer;

  localparam int LIVES = 3, MAX_LEVEL = 4, SPLASH_MIN = 60, RESPAWN_FR = 90, LEVELUP_FR = 60;
  localparam int FL = 8;  // clock cycles per frame
`ifdef PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  // Event bit order in the stimulus vector.
  localparam int B_START = 0, B_PAUSE = 1, B_HIT = 2, B_CLR = 3, B_LAND = 4;
  localparam logic [4:0] E_NONE = 5'd0, E_START = 5'b00001, E_PAUSE = 5'b00010,
                         E_HIT = 5'b00100, E_CLR = 5'b01000, E_LAND = 5'b10000;

  localparam int M_TITLE = 0, M_PLAY = 1, M_RESPAWN = 2, M_LVLUP = 3, M_OVER = 4, M_WIN = 5, M_PAUSE = 6;

  typedef struct packed {
    logic       gm;
    logic       se;
    logic [1:0] ss;
    logic       fz;
    logic       gp;
    logic [1:0] lives;
    logic [2:0] lvl;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  game_mode_sequencer_if bus ();

  game_mode_sequencer #(
    .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL), .SPLASH_MIN_FRAMES(SPLASH_MIN),
    .RESPAWN_FRAMES(RESPAWN_FR), .LEVELUP_FRAMES(LEVELUP_FR)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- reference model (phase level) ----------------
  int         ms;       // current phase
  int         mfr;      // frame boundaries seen in this phase
  int         mlives, mlevel;
  logic [4:0] pend;     // events waiting for the next frame boundary

  function automatic exp_t model_out(input logic gp);
    exp_t e;
    e.gm    = (ms == M_PLAY || ms == M_RESPAWN || ms == M_PAUSE);
    e.se    = (ms == M_TITLE || ms == M_LVLUP || ms == M_OVER || ms == M_WIN);
    e.ss    = (ms == M_LVLUP) ? 2'd1 : (ms == M_OVER) ? 2'd2 : (ms == M_WIN) ? 2'd3 : 2'd0;
    e.fz    = (ms == M_RESPAWN || ms == M_LVLUP || ms == M_PAUSE);
    e.gp    = gp;
    e.lives = 2'(mlives);
    e.lvl   = 3'(mlevel);
    return e;
  endfunction

  task automatic model_reset();
    ms = M_TITLE; mfr = 0; mlives = LIVES; mlevel = 1; pend = '0;
    expq.push_back(model_out(1'b0));
  endtask

  task automatic model_frame();
    int   nxt = ms;
    logic gp  = 1'b0;
    case (ms)
      M_TITLE:
        if (pend[B_START] && mfr >= SPLASH_MIN) begin
          nxt = M_PLAY; mlives = LIVES; mlevel = 1; gp = 1'b1;
        end
      M_PLAY:
        if (pend[B_LAND]) nxt = M_OVER;
        else if (pend[B_HIT]) begin
          mlives = mlives - 1;
          nxt = (mlives == 0) ? M_OVER : M_RESPAWN;
        end
        else if (pend[B_CLR]) nxt = (mlevel == MAX_LEVEL) ? M_WIN : M_LVLUP;
        else if (PAUSE_ON && pend[B_PAUSE]) nxt = M_PAUSE;
      M_RESPAWN: if (mfr == RESPAWN_FR - 1) nxt = M_PLAY;
      M_LVLUP:
        if (mfr == LEVELUP_FR - 1) begin
          nxt = M_PLAY; gp = 1'b1;
          if (mlevel < MAX_LEVEL) mlevel = mlevel + 1;
        end
      M_PAUSE: if (pend[B_PAUSE]) nxt = M_PLAY;
      default: if (pend[B_START] && mfr >= SPLASH_MIN) nxt = M_TITLE;  // game over / win
    endcase
    if (nxt != ms) mfr = 0;
    else if (mfr < 255) mfr = mfr + 1;
    ms = nxt;
    expq.push_back(model_out(gp));
  endtask

  task automatic model_step(input logic sof, input logic [4:0] ev);
    if (sof) begin
      model_frame();
      pend = ev;   // a pulse coincident with the boundary waits one more frame
    end else begin
      pend = pend | ev;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic sof, input logic [4:0] ev);
    bus.startOfFrame  = sof;
    bus.startKey      = ev[B_START];
    bus.pauseKey      = ev[B_PAUSE];
    bus.playerHit     = ev[B_HIT];
    bus.aliensCleared = ev[B_CLR];
    bus.aliensLanded  = ev[B_LAND];
    model_step(sof, ev);
  endtask

  // One frame; ev pulses at cycle 'at' (0 = coincident with startOfFrame).
  task automatic frame(input logic [4:0] ev, input int at);
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      drive(c == 0, (c == at) ? ev : E_NONE);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) frame(E_NONE, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, E_NONE);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    drive(1'b0, E_NONE);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    drive(1'b0, E_NONE);
  endtask

  // From TITLE: wait out the splash minimum, press start, land in PLAY.
  task automatic title_to_play();
    wait_frames(62);
    frame(E_START, $urandom_range(1, FL - 1));
    wait_frames(2);
  endtask

  // From GAME_OVER / WIN back to PLAY via TITLE.
  task automatic end_to_play();
    wait_frames(62);
    frame(E_START, $urandom_range(1, FL - 1));
    title_to_play();
  endtask

  // ---------------- monitor ----------------
  logic trig   = 1'b0;
  logic trig_d = 1'b0;
  exp_t cur    = '0;

  always @(posedge clk) begin
    trig   <= bus.startOfFrame | ~resetN;
    trig_d <= trig;
  end

  task automatic check(input string name, input exp_t e);
    exp_t got;
    got = {bus.isGameMode, bus.splashEn, bus.splashSel, bus.freeze, bus.gameResetPulse,
           bus.livesLeft, bus.level};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got gm=%0b se=%0b ss=%0d fz=%0b gp=%0b lives=%0d lvl=%0d, expected gm=%0b se=%0b ss=%0d fz=%0b gp=%0b lives=%0d lvl=%0d",
               name, $time, got.gm, got.se, got.ss, got.fz, got.gp, got.lives, got.lvl,
               e.gm, e.se, e.ss, e.fz, e.gp, e.lives, e.lvl);
    end
  endtask

  always @(negedge clk) begin
    if (trig) begin
      if (expq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty @%0t: got no expected entry, required one", $time);
      end else begin
        cur = expq.pop_front();
        check("boundary", cur);
      end
    end else if (trig_d) begin
      // One cycle later the reset pulse must be gone and everything else steady.
      exp_t hold;
      hold    = cur;
      hold.gp = 1'b0;
      check("hold", hold);
    end
  end

  // ---------------- sequence ----------------
  initial begin
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.startKey = 1'b0; bus.pauseKey = 1'b0;
    bus.playerHit = 1'b0; bus.aliensCleared = 1'b0; bus.aliensLanded = 1'b0;
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    drive(1'b0, E_NONE);

    // Early start is ignored, start after the splash minimum enters PLAY.
    wait_frames(10);
    frame(E_START, 3);
    wait_frames(50);
    frame(E_START, 5);
    wait_frames(3);

    // Three hits spaced beyond the respawn freeze; a hit during respawn is ignored.
    for (int h = 0; h < 3; h++) begin
      frame(E_HIT, $urandom_range(1, FL - 1));
      wait_frames(20);
      frame(E_HIT, 4);
      wait_frames(RESPAWN_FR + 2 - 21);
    end
    end_to_play();

    // Landing together with a hit: game over, lives untouched.
    frame(E_HIT | E_LAND, 2);
    wait_frames(2);
    end_to_play();

    // Pause, hit while paused, unpause.
    frame(E_PAUSE, 3);
    wait_frames(2);
    frame(E_HIT, 6);
    wait_frames(2);
    frame(E_PAUSE, 1);
    wait_frames(2);

    // Clear every level; the clear event lands on the frame boundary itself.
    for (int l = 0; l < MAX_LEVEL; l++) begin
      frame(E_CLR, 0);
      wait_frames(LEVELUP_FR + 3);
    end
    end_to_play();

    // Random traffic.
    for (int f = 0; f < 400; f++) begin
      logic [4:0] ev;
      for (int b = 0; b < 5; b++) ev[b] = ($urandom_range(0, 5) == 0);
      frame(ev, $urandom_range(0, FL - 1));
    end

    // Reset in the middle of a respawn freeze.
    do_reset();
    title_to_play();
    frame(E_HIT, 2);
    wait_frames(10);
    idle_cycles(3);
    do_reset();
    wait_frames(3);
    idle_cycles(3);

    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
